// File: rtl/bsg_parallel_in_serial_out_dynamic_buffered.sv
// Purpose: registers one parallel bundle of 1..els_p words and emits it one word per handshake.
// Latency: a bundle accepted at edge N presents its first word in cycle N+1; one word per cycle after that.
// Backpressure: data_o/last_o are held while ready_and_i is low; ready_and_o reopens combinationally on the last send.
module bsg_parallel_in_serial_out_dynamic_buffered #(
  // width_p and els_p are meant to be set by every instantiation; the values
  // below only let the block elaborate on its own.
  parameter int width_p       = 8,
  parameter int els_p         = 4,
  parameter int lg_max_els_lp = (els_p == 1) ? 1 : $clog2(els_p),
  parameter bit hi_to_lo_p    = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       v_i,
  input  logic [lg_max_els_lp-1:0]   len_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic                       ready_and_o,

  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       ready_and_i
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [els_p-1:0][width_p-1:0]     data_q;
  logic                              busy;
  logic                              last;
  logic                              load;
  logic                              send;

  assign busy = (state_q == ST_BUSY);
  assign send = busy & ready_and_i;

  // The ready path through last & ready_and_i lets a new bundle load in the
  // same cycle the previous one retires, so back-to-back bundles see no bubble.
  // Gating with reset_n_i keeps the upstream from handshaking during reset.
  assign ready_and_o = reset_n_i & (~busy | (last & ready_and_i));
  assign load        = v_i & ready_and_o;

  assign v_o    = busy;
  assign last_o = last;

  // Next-state: EMPTY -> BUSY on load; BUSY stays BUSY on a reload at the last send.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (send & last) begin
          state_d = load ? ST_BUSY : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register; asynchronous reset drops v_o immediately and discards any partial bundle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Bundle storage needs no reset: data_o is only meaningful while v_o is high.
  always_ff @(posedge clk_i) begin
    if (load) begin
      data_q <= data_i;
    end
  end

  if (els_p == 1) begin : g_single
    // A single-word bundle is always its own last word; len_i carries no information.
    logic unused_len;
    assign unused_len = ^len_i;

    assign last   = busy;
    assign data_o = data_q[0];
  end else begin : g_multi
    localparam logic [lg_max_els_lp-1:0] max_len_lp = lg_max_els_lp'(els_p - 1);

    logic [lg_max_els_lp-1:0] count_q, count_d;
    logic [lg_max_els_lp-1:0] len_q, len_d;
    logic [lg_max_els_lp-1:0] len_clamped;
    logic [lg_max_els_lp-1:0] word_idx;

    // Oversized lengths are clipped so a bundle never indexes past els_p words.
    assign len_clamped = (len_i > max_len_lp) ? max_len_lp : len_i;

    assign last = busy & (count_q == len_q);

    // Reversed order walks from the last valid word of this bundle down to word 0.
    assign word_idx = hi_to_lo_p ? (len_q - count_q) : count_q;
    assign data_o   = data_q[word_idx];

    // Counter/length next-state: a load restarts the count, a non-final send advances it.
    always_comb begin
      count_d = count_q;
      len_d   = len_q;
      if (load) begin
        count_d = '0;
        len_d   = len_clamped;
      end else if (send & ~last) begin
        count_d = count_q + 1'b1;
      end
    end

    // Counter and length registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        count_q <= '0;
        len_q   <= '0;
      end else begin
        count_q <= count_d;
        len_q   <= len_d;
      end
    end
  end

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_dynamic_buffered.sv
// Bench: three instances (els 4 low-first, els 4 high-first, els 3 low-first) checked
// against a word-queue model of the bundles in flight.
module tb_bsg_parallel_in_serial_out_dynamic_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  v_i, rdy_i, v_o, last_o, rdy_o;
  logic [1:0]  len_i;
  logic [31:0] data_bus;
  logic [7:0]  dout0, dout1, dout2;

  bsg_parallel_in_serial_out_dynamic_buffered #(
    .width_p(8), .els_p(4), .lg_max_els_lp(2), .hi_to_lo_p(1'b0)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[0]), .len_i(len_i), .data_i(data_bus),
    .ready_and_o(rdy_o[0]), .v_o(v_o[0]), .data_o(dout0), .last_o(last_o[0]),
    .ready_and_i(rdy_i[0])
  );

  bsg_parallel_in_serial_out_dynamic_buffered #(
    .width_p(8), .els_p(4), .lg_max_els_lp(2), .hi_to_lo_p(1'b1)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[1]), .len_i(len_i), .data_i(data_bus),
    .ready_and_o(rdy_o[1]), .v_o(v_o[1]), .data_o(dout1), .last_o(last_o[1]),
    .ready_and_i(rdy_i[1])
  );

  bsg_parallel_in_serial_out_dynamic_buffered #(
    .width_p(8), .els_p(3), .lg_max_els_lp(2), .hi_to_lo_p(1'b0)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[2]), .len_i(len_i), .data_i(data_bus[23:0]),
    .ready_and_o(rdy_o[2]), .v_o(v_o[2]), .data_o(dout2), .last_o(last_o[2]),
    .ready_and_i(rdy_i[2])
  );

  typedef struct {
    logic [7:0] w;
    logic       l;
  } ent_t;

  ent_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  logic        pend_v;
  logic [1:0]  pend_len;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  function automatic int els_of(input int s);
    return (s == 2) ? 3 : 4;
  endfunction

  // Expand an accepted bundle into the words the link must carry, in order.
  task automatic push_bundle(input int s, input logic [1:0] len, input logic [31:0] d);
    int   n;
    int   idx;
    ent_t e;
    n = int'(len);
    if (n > els_of(s) - 1) n = els_of(s) - 1;
    n = n + 1;
    for (int k = 0; k < n; k++) begin
      idx = (s == 1) ? (n - 1 - k) : k;
      e.w = d[idx*8 +: 8];
      e.l = (k == n - 1);
      expq.push_back(e);
    end
  endtask

  // One clock cycle on instance s: drive, check pre-edge outputs, advance the model.
  task automatic cycle(input int s, input logic rdy);
    logic       ev, er;
    logic [7:0] dsel;
    cur      = s;
    v_i      = '0;
    rdy_i    = '0;
    v_i[s]   = pend_v;
    rdy_i[s] = rdy;
    len_i    = pend_len;
    data_bus = pend_data;
    #1;
    ev   = (expq.size() > 0);
    er   = !ev || (expq[0].l && rdy);
    dsel = (s == 0) ? dout0 : (s == 1) ? dout1 : dout2;
    chk("v_o", 32'(v_o[s]), 32'(ev));
    chk("ready_and_o", 32'(rdy_o[s]), 32'(er));
    if (ev) begin
      chk("data_o", 32'(dsel), 32'(expq[0].w));
      chk("last_o", 32'(last_o[s]), 32'(expq[0].l));
    end
    if (ev && rdy) void'(expq.pop_front());
    if (pend_v && er) begin
      push_bundle(s, pend_len, pend_data);
      pend_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] len, input logic [31:0] d);
    pend_v    = 1'b1;
    pend_len  = len;
    pend_data = d;
  endtask

  task automatic drain(input int s);
    int b;
    b = 0;
    while ((expq.size() > 0 || pend_v) && b < 40) begin
      cycle(s, 1'b1);
      b++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    v_i       = '0;
    rdy_i     = '0;
    len_i     = '0;
    data_bus  = '0;
    pend_v    = 1'b0;
    pend_len  = '0;
    pend_data = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      cur = s;
      chk("reset v_o", 32'(v_o[s]), 32'd0);
      chk("reset last_o", 32'(last_o[s]), 32'd0);
      chk("reset ready_and_o", 32'(rdy_o[s]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      cur = s;
      chk("post-reset ready_and_o", 32'(rdy_o[s]), 32'd1);
    end
    @(negedge clk);

    // Basic order, low index first.
    offer(2'd3, 32'h44332211);
    for (int i = 0; i < 6; i++) cycle(0, 1'b1);

    // Short bundle, high index first: 0x22 then 0x11.
    offer(2'd1, 32'h44332211);
    for (int i = 0; i < 4; i++) cycle(1, 1'b1);

    // Back-to-back single-word bundles with no bubble.
    offer(2'd0, 32'h000000AA);
    cycle(0, 1'b1);
    offer(2'd0, 32'h000000BB);
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    cycle(0, 1'b1);

    // Backpressure pattern 1,0,0,1,1 on a three-word bundle.
    offer(2'd2, 32'h00332211);
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    cycle(0, 1'b1);

    // Clamp: len 3 on a three-entry instance emits exactly three words.
    offer(2'd3, 32'h00332211);
    for (int i = 0; i < 5; i++) cycle(2, 1'b1);

    // Asynchronous reset mid-bundle.
    offer(2'd3, 32'h44332211);
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    v_i      = '0;
    rdy_i    = '0;
    rdy_i[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    cur = 0;
    chk("async reset v_o", 32'(v_o[0]), 32'd0);
    chk("async reset ready_and_o", 32'(rdy_o[0]), 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release ready_and_o", 32'(rdy_o[0]), 32'd1);
    chk("release v_o", 32'(v_o[0]), 32'd0);
    @(negedge clk);
    offer(2'd0, 32'h0000005A);
    for (int i = 0; i < 3; i++) cycle(0, 1'b1);

    // Randomized traffic and backpressure on every instance.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 200; i++) begin
        if (!pend_v && $urandom_range(0, 2) != 0) begin
          offer(2'($urandom_range(0, 3)), $urandom);
        end
        cycle(s, ($urandom_range(0, 3) != 0));
      end
      drain(s);
      cycle(s, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
